// File: rtl/piso_word_reader_if.sv
// piso_word_reader_if
//   Bundles the parallel load handshake and the serial output handshake of
//   piso_word_reader.
//   Signals:
//     load_valid  upstream word on load_data is valid
//     load_ready  reader can accept a word
//     load_data   parallel word to read out (WIDTH bits)
//     ser_out     current serial bit
//     ser_valid   ser_out holds a valid bit
//     ser_ready   downstream accepts ser_out this cycle
//     ser_last    current bit is the final bit of the word
//     busy        a word is in flight
//   Modports:
//     slave   the reader itself
//     master  the environment driving loads and consuming bits
interface piso_word_reader_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;
    logic             busy;

    modport slave (
        input  load_valid,
        input  load_data,
        input  ser_ready,
        output load_ready,
        output ser_out,
        output ser_valid,
        output ser_last,
        output busy
    );

    modport master (
        output load_valid,
        output load_data,
        output ser_ready,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_last,
        input  busy
    );
endinterface

// File: rtl/piso_word_reader.sv
// piso_word_reader
//   Accepts one parallel word over a valid/ready handshake and shifts it out
//   one bit per accepted serial beat, MSB or LSB first.
//   Ports:
//     clk    system clock, all state changes on posedge
//     rst_n  synchronous reset, active low
//     bus    piso_word_reader_if.slave: load_valid/load_ready/load_data in,
//            ser_out/ser_valid/ser_ready/ser_last out, busy out
//   Parameters:
//     WIDTH      bits per word, 2..32
//     MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
module piso_word_reader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    piso_word_reader_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] shifted;

    // Shift one place toward the send end, zero-filling the far end.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shifted[gi] = shreg_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shifted[gi] = shreg_reg[gi+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                // load_data is only looked at on a real handshake, so an
                // undriven bus while load_valid is low never reaches shreg.
                if (bus.load_valid) begin
                    shreg_next = bus.load_data;
                    count_next = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ser_ready) begin
                    if (count_reg == LAST_COUNT) begin
                        // Last bit stays in shreg; the IDLE cycle that follows
                        // is the mandatory bubble between words.
                        state_next = IDLE;
                    end else begin
                        count_next = count_reg + CW'(1);
                        shreg_next = shifted;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.load_ready = (state_reg == IDLE);
    assign bus.ser_valid  = (state_reg == SHIFT);
    assign bus.busy       = (state_reg == SHIFT);
    assign bus.ser_last   = (state_reg == SHIFT) && (count_reg == LAST_COUNT);
    assign bus.ser_out    = MSB_FIRST ? shreg_reg[WIDTH-1] : shreg_reg[0];
endmodule

// File: tb/tb_piso_word_reader.sv
// tb_piso_word_reader
//   Drives an MSB-first and an LSB-first reader with identical stimulus and
//   checks both every cycle against a word/bit-index model, plus literal
//   word checks for directed loads.
module tb_piso_word_reader;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    logic lv;
    logic [W-1:0] ld;
    logic sr;

    piso_word_reader_if #(.WIDTH(W)) bus_m ();
    piso_word_reader_if #(.WIDTH(W)) bus_l ();

    assign bus_m.load_valid = lv;
    assign bus_m.load_data  = ld;
    assign bus_m.ser_ready  = sr;
    assign bus_l.load_valid = lv;
    assign bus_l.load_data  = ld;
    assign bus_l.ser_ready  = sr;

    piso_word_reader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m)
    );

    piso_word_reader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic armed = 1'b0;

    // Model: the word in flight and how many of its bits were already taken.
    logic         m_busy = 1'b0;
    logic [W-1:0] m_word = '0;
    int           m_k    = 0;

    // Bits actually accepted from each DUT, oldest at the high end.
    logic [31:0] cap_m = '0;
    logic [31:0] cap_l = '0;
    int          beats = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_k    <= 0;
        end else if (!m_busy) begin
            if (lv) begin
                m_busy <= 1'b1;
                m_word <= ld;
                m_k    <= 0;
            end
        end else if (sr) begin
            if (m_k == W - 1) m_busy <= 1'b0;
            else              m_k    <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk1("m.load_ready", bus_m.load_ready, !m_busy);
            chk1("m.ser_valid",  bus_m.ser_valid,  m_busy);
            chk1("m.busy",       bus_m.busy,       m_busy);
            chk1("m.ser_last",   bus_m.ser_last,   m_busy && (m_k == W - 1));
            chk1("l.load_ready", bus_l.load_ready, !m_busy);
            chk1("l.ser_valid",  bus_l.ser_valid,  m_busy);
            chk1("l.ser_last",   bus_l.ser_last,   m_busy && (m_k == W - 1));
            if (m_busy) begin
                chk1("m.ser_out", bus_m.ser_out, m_word[W-1-m_k]);
                chk1("l.ser_out", bus_l.ser_out, m_word[m_k]);
            end
            if (rst_n && sr && bus_m.ser_valid) begin
                cap_m <= {cap_m[30:0], bus_m.ser_out};
                cap_l <= {cap_l[30:0], bus_l.ser_out};
                beats <= beats + 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        logic [31:0] r;
        r     = $urandom;
        rst_n = 1'b0;
        lv    = 1'b1;
        ld    = r[W-1:0];
        repeat (n) cyc();
        chk1("rst.m.load_ready", bus_m.load_ready, 1'b1);
        chk1("rst.m.ser_valid",  bus_m.ser_valid,  1'b0);
        chk1("rst.m.busy",       bus_m.busy,       1'b0);
        chk1("rst.m.ser_last",   bus_m.ser_last,   1'b0);
        chk1("rst.m.ser_out",    bus_m.ser_out,    1'b0);
        chk1("rst.l.ser_out",    bus_l.ser_out,    1'b0);
        chk1("rst.l.busy",       bus_l.busy,       1'b0);
        lv    = 1'b0;
        ld    = 'x;
        rst_n = 1'b1;
    endtask

    task automatic send_word(input logic [W-1:0] data, input bit keep_valid,
                             input int stall_after, input int stall_len,
                             input int abort_after,
                             input logic [31:0] exp_m, input logic [31:0] exp_l);
        int guard;
        int done;
        int stalls;
        int b0;
        int nbits;
        logic [31:0] mask;
        guard = 0;
        while (m_busy && guard < 100) begin
            cyc();
            guard++;
        end
        b0 = beats;
        lv = 1'b1;
        ld = data;
        sr = 1'b1;
        cyc();
        if (keep_valid) begin
            ld = '0;
        end else begin
            lv = 1'b0;
            ld = 'x;
        end
        done   = 0;
        stalls = 0;
        guard  = 0;
        while (m_busy && guard < 200) begin
            if (abort_after >= 0 && done == abort_after) begin
                rst_n = 1'b0;
                sr    = 1'b1;
                cyc();
                rst_n = 1'b1;
                chk1("abort.m.ser_valid", bus_m.ser_valid, 1'b0);
                chk1("abort.l.busy",      bus_l.busy,      1'b0);
                break;
            end
            if (done == stall_after && stalls < stall_len) begin
                sr = 1'b0;
                stalls++;
            end else begin
                sr = 1'b1;
            end
            cyc();
            if (sr) done++;
            guard++;
        end
        chk1("word.timeout", m_busy && guard >= 200, 1'b0);
        lv    = 1'b0;
        ld    = 'x;
        sr    = 1'b0;
        nbits = (abort_after >= 0) ? abort_after : W;
        mask  = (32'd1 << nbits) - 32'd1;
        chkw("word.beats", 32'(beats - b0), 32'(nbits));
        chkw("word.m_bits", cap_m & mask, exp_m);
        chkw("word.l_bits", cap_l & mask, exp_l);
        $display("word %02h: msb-first bits %0h, lsb-first bits %0h, %0d beats",
                 data, cap_m & mask, cap_l & mask, beats - b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        rst_n = 1'b0;
        lv    = 1'b0;
        ld    = '0;
        sr    = 1'b0;
        do_reset(2);
        armed = 1'b1;
        cyc();

        // Directed words; the LSB-first capture reads the bit stream in send order.
        send_word(8'hA5, 1'b0, -1, 0, -1, 32'hA5, 32'hA5);
        send_word(8'h01, 1'b0, -1, 0, -1, 32'h01, 32'h80);
        send_word(8'hF0, 1'b0,  2, 3, -1, 32'hF0, 32'h0F);
        send_word(8'hFF, 1'b1, -1, 0, -1, 32'hFF, 32'hFF);
        send_word(8'hC3, 1'b0, -1, 0,  3, 32'h6,  32'h6);
        send_word(8'h3C, 1'b0, -1, 0, -1, 32'h3C, 32'h3C);

        // Random loads, backpressure and occasional resets.
        for (int i = 0; i < 600; i++) begin
            r     = $urandom;
            rst_n = (r[5:0] != 6'd0);
            lv    = (r[9:8] == 2'd0);
            ld    = lv ? r[23:16] : 'x;
            sr    = (r[13:12] != 2'd0);
            cyc();
        end
        rst_n = 1'b1;
        lv    = 1'b0;
        sr    = 1'b1;
        repeat (W + 2) cyc();
        send_word(8'h5A, 1'b0, 5, 2, -1, 32'h5A, 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
